check_ram: RTL

//  Read-back checker for one RAM bank. Issues AXI4 INCR read bursts across the whole bank and

---
 rtl/check_ram_if.sv | 34 +++
 rtl/check_ram.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/check_ram_if.sv
// check_ram_if: AXI4 port of the bank checker; the read channels carry traffic,
// the write channels exist only so the master can hold them idle.
interface check_ram_if #(parameter int DW = 512);
  logic [63:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst;
  logic [3:0] arid, arcache, arqos;
  logic arlock, arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [3:0] awid, awcache, awqos;
  logic awlock, awvalid;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, wvalid, bready;
  modport master(
    output araddr, arlen, arsize, arprot, arburst, arid, arcache, arqos, arlock, arvalid,
    input arready, rdata, rresp, rlast, rvalid,
    output rready, awaddr, awlen, awsize, awprot, awburst, awid, awcache, awqos, awlock,
    output awvalid, wdata, wstrb, wlast, wvalid, bready
  );
  modport slave(
    input araddr, arlen, arsize, arprot, arburst, arid, arcache, arqos, arlock, arvalid,
    output arready, rdata, rresp, rlast, rvalid,
    input rready, awaddr, awlen, awsize, awprot, awburst, awid, awcache, awqos, awlock,
    input awvalid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/check_ram.sv
// check_ram: reads a whole RAM bank in INCR bursts and checks every byte against a fill value,
// reporting mismatching beats, the first failing address, RRESP/RLAST faults and elapsed cycles.
module check_ram #(
  parameter int DW = 512,
  parameter logic [7:0] FILL_VALUE = 8'hFC,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int BLOCK_BYTES = 4096,
  parameter int BLOCK_CYCLES = 64,
  parameter int BLOCK_COUNT = 1024
) (
  input logic ram_clk,
  input logic ram_resetn,
  input logic start,
  output logic idle,
  output logic [63:0] elapsed,
  output logic [63:0] error_count,
  output logic [63:0] first_err_addr,
  output logic [31:0] rresp_errors,
  output logic rlast_error,
  check_ram_if.master m_axi
);
  localparam int BW = $clog2(BLOCK_CYCLES + 1);
  localparam int KW = $clog2(BLOCK_COUNT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BLOCK_CYCLES);
  localparam logic [KW-1:0] BLOCK_LAST = KW'(BLOCK_COUNT);
  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} r_state_t;
  ar_state_t ar_state_q, ar_state_d;
  r_state_t r_state_q, r_state_d;
  logic [63:0] araddr_q, araddr_d, beat_addr_q, beat_addr_d, s1_addr_q, s1_addr_d;
  logic [63:0] elapsed_q, elapsed_d, err_q, err_d, first_q, first_d;
  logic [31:0] resp_q, resp_d;
  logic [KW-1:0] ar_count_q, ar_count_d, block_q, block_d;
  logic [BW-1:0] beat_q, beat_d;
  logic s1_v_q, s1_v_d, s1_mis_q, s1_mis_d, s1_bad_q, s1_bad_d, rlast_err_q, rlast_err_d;
  logic go;
  assign idle = r_state_q == R_IDLE;
  assign go = start & idle;
  assign elapsed = elapsed_q;
  assign error_count = err_q;
  assign first_err_addr = first_q;
  assign rresp_errors = resp_q;
  assign rlast_error = rlast_err_q;
  assign m_axi.araddr = araddr_q;
  assign m_axi.arvalid = ar_state_q == AR_SEND;
  assign m_axi.arlen = 8'(BLOCK_CYCLES - 1);
  assign m_axi.arsize = 3'($clog2(DW / 8));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arid = '0;
  assign m_axi.arcache = '0;
  assign m_axi.arqos = '0;
  assign m_axi.arprot = '0;
  assign m_axi.arlock = 1'b0;
  assign m_axi.rready = 1'b1;
  assign m_axi.awaddr = '0;
  assign m_axi.awlen = '0;
  assign m_axi.awsize = '0;
  assign m_axi.awprot = '0;
  assign m_axi.awburst = '0;
  assign m_axi.awid = '0;
  assign m_axi.awcache = '0;
  assign m_axi.awqos = '0;
  assign m_axi.awlock = 1'b0;
  assign m_axi.awvalid = 1'b0;
  assign m_axi.wdata = '0;
  assign m_axi.wstrb = '0;
  assign m_axi.wlast = 1'b0;
  assign m_axi.wvalid = 1'b0;
  assign m_axi.bready = 1'b1;
  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d = araddr_q;
    ar_count_d = ar_count_q;
    if (ar_state_q == AR_IDLE) begin
      if (go) begin
        ar_state_d = AR_SEND;
        araddr_d = BASE_ADDR;
        ar_count_d = KW'(1);
      end
    end else if (m_axi.arready) begin
      if (ar_count_q == BLOCK_LAST) ar_state_d = AR_IDLE;
      else begin
        araddr_d = araddr_q + 64'(BLOCK_BYTES);
        ar_count_d = ar_count_q + 1'b1;
      end
    end
  end
  // Stage 2 retires the beat registered last cycle; the case below may then override on start.
  always_comb begin
    r_state_d = r_state_q;
    beat_d = beat_q;
    block_d = block_q;
    beat_addr_d = beat_addr_q;
    s1_v_d = 1'b0;
    s1_mis_d = s1_mis_q;
    s1_bad_d = s1_bad_q;
    s1_addr_d = s1_addr_q;
    elapsed_d = idle ? elapsed_q : elapsed_q + 64'd1;
    err_d = s1_v_q ? err_q + 64'(s1_mis_q) : err_q;
    resp_d = (s1_v_q && s1_bad_q && resp_q != '1) ? resp_q + 32'd1 : resp_q;
    first_d = (s1_v_q && s1_mis_q && err_q == 64'd0) ? s1_addr_q : first_q;
    rlast_err_d = rlast_err_q;
    case (r_state_q)
      R_IDLE: if (start) begin
        r_state_d = R_RUN;
        beat_d = BW'(1);
        block_d = KW'(1);
        beat_addr_d = BASE_ADDR;
        elapsed_d = '0;
        err_d = '0;
        resp_d = '0;
        first_d = '1;
        rlast_err_d = 1'b0;
      end
      R_RUN: if (m_axi.rvalid) begin
        s1_v_d = 1'b1;
        s1_mis_d = |(m_axi.rdata ^ {(DW / 8){FILL_VALUE}});
        s1_bad_d = m_axi.rresp != 2'b00;
        s1_addr_d = beat_addr_q;
        rlast_err_d = rlast_err_q | (m_axi.rlast != (beat_q == BEAT_LAST));
        beat_addr_d = beat_addr_q + 64'(DW / 8);
        beat_d = (beat_q == BEAT_LAST) ? BW'(1) : beat_q + 1'b1;
        block_d = (beat_q == BEAT_LAST) ? block_q + 1'b1 : block_q;
        r_state_d = (beat_q == BEAT_LAST && block_q == BLOCK_LAST) ? R_DRAIN : R_RUN;
      end
      R_DRAIN: r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge ram_clk or negedge ram_resetn)
    if (!ram_resetn) begin
      ar_state_q <= AR_IDLE;
      r_state_q <= R_IDLE;
      araddr_q <= BASE_ADDR;
      ar_count_q <= KW'(1);
      beat_q <= BW'(1);
      block_q <= KW'(1);
      beat_addr_q <= BASE_ADDR;
      s1_v_q <= 1'b0;
      s1_mis_q <= 1'b0;
      s1_bad_q <= 1'b0;
      s1_addr_q <= '0;
      elapsed_q <= '0;
      err_q <= '0;
      resp_q <= '0;
      first_q <= '1;
      rlast_err_q <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      r_state_q <= r_state_d;
      araddr_q <= araddr_d;
      ar_count_q <= ar_count_d;
      beat_q <= beat_d;
      block_q <= block_d;
      beat_addr_q <= beat_addr_d;
      s1_v_q <= s1_v_d;
      s1_mis_q <= s1_mis_d;
      s1_bad_q <= s1_bad_d;
      s1_addr_q <= s1_addr_d;
      elapsed_q <= elapsed_d;
      err_q <= err_d;
      resp_q <= resp_d;
      first_q <= first_d;
      rlast_err_q <= rlast_err_d;
    end
endmodule
